macro_pending_arbiter: RTL and testbench

MACRO_PENDING_ARBITER -- requirements
Module: macro_pending_arbiter

---
 rtl/macro_pending_arbiter.sv | 99 +++++++++
 tb/tb_macro_pending_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/macro_pending_arbiter.sv
// Sticky pending-event register with a registered round-robin grant stage.
// Events on enabled lines latch until granted; one grant per handshake, back-to-back capable.
module macro_pending_arbiter #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned INDEX_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [INPUT_WIDTH-1:0] d,
  input  logic [INPUT_WIDTH-1:0] mask,
  input  logic                   flush,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [INPUT_WIDTH-1:0] o_onehot,
  output logic [INPUT_WIDTH-1:0] pending
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OFFER = 1'b1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(INPUT_WIDTH - 1);

  logic                   r_state;
  logic [INPUT_WIDTH-1:0] r_pending;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [INPUT_WIDTH-1:0] r_onehot;
  logic [INDEX_WIDTH-1:0] r_ptr;

  logic                     w_hs;
  logic [INPUT_WIDTH-1:0]   w_clr;
  logic [INPUT_WIDTH-1:0]   w_eligible;
  logic [INDEX_WIDTH-1:0]   w_next_ptr;
  logic [INDEX_WIDTH-1:0]   w_start;
  logic [2*INPUT_WIDTH-1:0] w_dbl;
  logic [INPUT_WIDTH-1:0]   w_rot;
  logic                     w_found;
  logic [INDEX_WIDTH-1:0]   w_win_idx;
  logic [INPUT_WIDTH-1:0]   w_win_oh;
  int unsigned              w_sum;

  assign w_hs       = (r_state == ST_OFFER) && o_ready;
  assign w_clr      = w_hs ? r_onehot : '0;
  assign w_eligible = r_pending & mask & ~w_clr;
  assign w_next_ptr = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
  // Search begins after the line being granted now, so back-to-back grants rotate.
  assign w_start    = w_hs ? w_next_ptr : r_ptr;
  assign w_dbl      = {w_eligible, w_eligible} >> w_start;
  assign w_rot      = w_dbl[INPUT_WIDTH-1:0];

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_sum     = 0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = int'(w_start) + i;
        if (w_sum >= INPUT_WIDTH) w_sum = w_sum - INPUT_WIDTH;
        w_win_idx = INDEX_WIDTH'(w_sum);
      end
    end
    w_win_oh = INPUT_WIDTH'(1) << w_win_idx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_index   <= '0;
      r_onehot  <= '0;
      r_ptr     <= '0;
    end else begin
      if (w_hs) r_ptr <= w_next_ptr;
      if (flush) begin
        r_state   <= ST_IDLE;
        r_pending <= '0;
        r_onehot  <= '0;
      end else begin
        r_pending <= (r_pending & ~w_clr) | (d & mask);
        if (r_state == ST_IDLE || w_hs) begin
          if (w_found) begin
            r_state  <= ST_OFFER;
            r_index  <= w_win_idx;
            r_onehot <= w_win_oh;
          end else begin
            r_state  <= ST_IDLE;
            r_onehot <= '0;
          end
        end
      end
    end
  end

  assign o_valid  = (r_state == ST_OFFER);
  assign o_index  = r_index;
  assign o_onehot = r_onehot;
  assign pending  = r_pending;

endmodule

// File: tb/tb_macro_pending_arbiter.sv
// Directed-vector bench for macro_pending_arbiter with hand-computed expectations.
module tb_macro_pending_arbiter;

  logic       clk;
  logic       resetn;
  logic [7:0] d;
  logic [7:0] mask;
  logic       flush;
  logic       o_valid;
  logic       o_ready;
  logic [2:0] o_index;
  logic [7:0] o_onehot;
  logic [7:0] pending;

  int n_cmp;
  int n_err;

  macro_pending_arbiter #(
    .INPUT_WIDTH(8),
    .INDEX_WIDTH(3)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .d       (d),
    .mask    (mask),
    .flush   (flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_index (o_index),
    .o_onehot(o_onehot),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'h0);
    chk({tag, ".onehot"}, 64'(o_onehot), 64'h0);
  endtask

  task automatic chk_offer(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    chk({tag, ".valid"}, 64'(o_valid), 64'h1);
    chk({tag, ".index"}, 64'(o_index), 64'(idx));
    chk({tag, ".onehot"}, 64'(o_onehot), 64'(oh));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetn  = 1'b0;
    d       = 8'hFF;
    mask    = 8'hFF;
    flush   = 1'b0;
    o_ready = 1'b0;

    // Reset held with all lines firing
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.pending", 64'(pending), 64'h00);
      chk_idle("rst");
      chk("rst.index", 64'(o_index), 64'h0);
    end
    resetn = 1'b1;
    d      = 8'h00;
    tick();
    chk("rel.pending", 64'(pending), 64'h00);
    chk_idle("rel");

    // Single event on line 4
    o_ready = 1'b1;
    d       = 8'h10;
    tick();
    chk("single.e0.pending", 64'(pending), 64'h10);
    chk_idle("single.e0");
    d = 8'h00;
    tick();
    chk_offer("single.e1", 3'd4);
    tick();
    chk_idle("single.e2");
    chk("single.e2.pending", 64'(pending), 64'h00);
    chk("single.e2.ptr", 64'(dut.r_ptr), 64'h5);

    // Fairness: 0,1,2,3,0 with re-injection on line 0
    d = 8'h0F;
    tick();
    chk("fair.pending", 64'(pending), 64'h0F);
    d = 8'h00;
    tick();
    chk_offer("fair.g0", 3'd0);
    tick();
    chk_offer("fair.g1", 3'd1);
    d = 8'h01;
    tick();
    chk_offer("fair.g2", 3'd2);
    chk("fair.g2.pending", 64'(pending), 64'h0D);
    d = 8'h00;
    tick();
    chk_offer("fair.g3", 3'd3);
    tick();
    chk_offer("fair.g4", 3'd0);
    tick();
    chk_idle("fair.end");
    chk("fair.end.pending", 64'(pending), 64'h00);
    chk("fair.end.ptr", 64'(dut.r_ptr), 64'h1);

    // Backpressure holds the offer
    o_ready = 1'b0;
    d       = 8'h06;
    tick();
    d = 8'h00;
    tick();
    chk_offer("bp.hold0", 3'd1);
    d = 8'h01;
    tick();
    chk_offer("bp.hold1", 3'd1);
    chk("bp.pending", 64'(pending), 64'h07);
    d = 8'h00;
    tick();
    chk_offer("bp.hold2", 3'd1);
    o_ready = 1'b1;
    tick();
    chk_offer("bp.g2", 3'd2);
    chk("bp.ptr", 64'(dut.r_ptr), 64'h2);
    tick();
    chk_offer("bp.g0", 3'd0);
    tick();
    chk_idle("bp.end");

    // Set wins over clear on line 3
    o_ready = 1'b0;
    d       = 8'h08;
    tick();
    d = 8'h00;
    tick();
    chk_offer("sw.offer", 3'd3);
    o_ready = 1'b1;
    d       = 8'h08;
    tick();
    chk("sw.pending", 64'(pending), 64'h08);
    chk_idle("sw.gap");
    d = 8'h00;
    tick();
    chk_offer("sw.reoffer", 3'd3);
    tick();
    chk_idle("sw.end");

    // Masked line discards its event
    mask = 8'hFE;
    d    = 8'h01;
    tick();
    chk("mask.pending", 64'(pending), 64'h00);
    d = 8'h00;
    tick();
    chk_idle("mask.none");
    mask = 8'hFF;

    // Flush during offer, same-cycle event discarded
    o_ready = 1'b0;
    d       = 8'hF0;
    tick();
    d = 8'h00;
    tick();
    chk_offer("fl.offer", 3'd4);
    flush = 1'b1;
    d     = 8'h01;
    tick();
    chk("fl.pending", 64'(pending), 64'h00);
    chk_idle("fl.after");
    chk("fl.ptr", 64'(dut.r_ptr), 64'h4);
    flush = 1'b0;
    d     = 8'h00;
    tick();
    chk_idle("fl.stay");

    // Reset mid-offer drops valid without handshake
    d = 8'h02;
    tick();
    d = 8'h00;
    tick();
    chk_offer("mr.offer", 3'd1);
    resetn = 1'b0;
    tick();
    chk_idle("mr.rst");
    chk("mr.index", 64'(o_index), 64'h0);
    chk("mr.ptr", 64'(dut.r_ptr), 64'h0);
    chk("mr.pending", 64'(pending), 64'h00);
    resetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
